// File: rtl/exe_pkg.sv
// exe_pkg: shared constants for the execute stage.
//  - ALUC_* : 3-bit ALU opcodes (SLL is ALUC_XOR with exe_shift=1)
//  - state_t: iterative shifter FSM encoding (S_IDLE, S_SHIFT)
//  - SA_W / SA_LSB: shift-amount width and its position inside exe_imm
//  - mem_ctrl_t: EXE->MEM control bits
package exe_pkg;
   localparam logic [2:0] ALUC_ADD = 3'b000;
   localparam logic [2:0] ALUC_SUB = 3'b001;
   localparam logic [2:0] ALUC_AND = 3'b010;
   localparam logic [2:0] ALUC_OR  = 3'b011;
   localparam logic [2:0] ALUC_XOR = 3'b100;
   localparam logic [2:0] ALUC_LUI = 3'b101;
   localparam logic [2:0] ALUC_SRL = 3'b110;
   localparam logic [2:0] ALUC_SRA = 3'b111;

   localparam int SA_W   = 5;
   localparam int SA_LSB = 6;

   typedef enum logic {S_IDLE = 1'b0, S_SHIFT = 1'b1} state_t;

   typedef struct packed {
      logic valid;
      logic m2reg;
      logic wmem;
      logic wreg;
   } mem_ctrl_t;
endpackage

// File: rtl/exe_iter_shifter.sv
// exe_iter_shifter: 1-bit/cycle shifter used by the execute stage.
//  clk, clrn  : clock, async active-low reset
//  start      : request a shift (honoured only in S_IDLE)
//  dir_right  : 1 = right shift, 0 = left shift
//  arith      : right shift fills with the sign bit
//  sa, b      : shift amount (non-zero when start) and value to shift
//  busy       : FSM in S_SHIFT
//  done       : last shift cycle; result is valid this cycle
//  result     : value after the shift that completes at the coming edge
import exe_pkg::*;

module exe_iter_shifter #(
   parameter int WIDTH = 32,
   parameter int SA_W  = 5
) (
   input  logic             clk,
   input  logic             clrn,
   input  logic             start,
   input  logic             dir_right,
   input  logic             arith,
   input  logic [SA_W-1:0]  sa,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result
);
   state_t           state, state_nx;
   logic [WIDTH-1:0] sh, sh_step;
   logic [SA_W-1:0]  cnt;

   // The start edge only loads sh; the n-th shift happens on the done edge,
   // so the final value is taken from the combinational next step.
   assign sh_step = dir_right ? {arith & sh[WIDTH-1], sh[WIDTH-1:1]}
                              : {sh[WIDTH-2:0], 1'b0};
   assign busy    = (state == S_SHIFT);
   assign done    = busy && (cnt == SA_W'(1));
   assign result  = sh_step;

   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE:  if (start) state_nx = S_SHIFT;
         S_SHIFT: if (cnt == SA_W'(1)) state_nx = S_IDLE;
         default: state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         state <= S_IDLE;
         sh    <= '0;
         cnt   <= '0;
      end else begin
         state <= state_nx;
         if (state == S_IDLE) begin
            if (start) begin
               sh  <= b;
               cnt <= sa;
            end
         end else begin
            sh  <= sh_step;
            cnt <= cnt - SA_W'(1);
         end
      end
   end
endmodule

// File: rtl/exe_stage.sv
// exe_stage: execute stage, consumer of the ID->EXE register.
//  Computes the ALU result and registers it into EXE->MEM. Shifts with a
//  non-zero amount run on exe_iter_shifter and stall upstream meanwhile.
//  Inputs : clk, clrn, exe_valid/m2reg/wmem/aluimm/shift/wreg, exe_aluc,
//           exe_rn, exe_ra, exe_rb, exe_imm
//  Outputs: stall (combinational), registered mem_valid/m2reg/wmem/wreg,
//           mem_rn, mem_alu, mem_rb, and mem_ovf when built with
//           EXE_OVF_TRAP_EN (signed ADD/SUB overflow suppresses mem_wreg).
import exe_pkg::*;

module exe_stage #(
   parameter int WIDTH = 32,
   parameter int SA_W  = exe_pkg::SA_W
) (
   input  logic             clk,
   input  logic             clrn,
   input  logic             exe_valid,
   input  logic             exe_m2reg,
   input  logic             exe_wmem,
   input  logic             exe_aluimm,
   input  logic             exe_shift,
   input  logic             exe_wreg,
   input  logic [2:0]       exe_aluc,
   input  logic [4:0]       exe_rn,
   input  logic [WIDTH-1:0] exe_ra,
   input  logic [WIDTH-1:0] exe_rb,
   input  logic [WIDTH-1:0] exe_imm,
   output logic             stall,
   output logic             mem_valid,
   output logic             mem_m2reg,
   output logic             mem_wmem,
   output logic             mem_wreg,
   output logic [4:0]       mem_rn,
   output logic [WIDTH-1:0] mem_alu,
`ifdef EXE_OVF_TRAP_EN
   output logic             mem_ovf,
`endif
   output logic [WIDTH-1:0] mem_rb
);
   logic [SA_W-1:0]  sa;
   logic [WIDTH-1:0] a_op, b_op, alu_res, sum, diff, sh_result;
   logic             shift_op, start_shift, sh_busy, sh_done;
   mem_ctrl_t        ctrl_q, exe_ctrl;

   assign sa       = exe_imm[SA_LSB +: SA_W];
   assign a_op     = exe_shift ? {{(WIDTH-SA_W){1'b0}}, sa} : exe_ra;
   assign b_op     = exe_aluimm ? exe_imm : exe_rb;
   assign sum      = a_op + b_op;
   assign diff     = a_op - b_op;
   assign exe_ctrl = '{valid: exe_valid, m2reg: exe_m2reg, wmem: exe_wmem, wreg: exe_wreg};

   assign shift_op    = exe_shift && (exe_aluc == ALUC_XOR || exe_aluc == ALUC_SRL ||
                                      exe_aluc == ALUC_SRA);
   assign start_shift = exe_valid && exe_shift && (sa != '0);

   // Single-cycle path; a shift reaching here has sa==0, so it passes B through.
   always_comb begin
      alu_res = sum;
      case (exe_aluc)
         ALUC_ADD: alu_res = sum;
         ALUC_SUB: alu_res = diff;
         ALUC_AND: alu_res = a_op & b_op;
         ALUC_OR:  alu_res = a_op | b_op;
         ALUC_XOR: alu_res = a_op ^ b_op;
         ALUC_LUI: alu_res = b_op << 16;
         default:  alu_res = b_op;
      endcase
      if (shift_op) alu_res = b_op;
   end

`ifdef EXE_OVF_TRAP_EN
   logic ovf;
   always_comb begin
      ovf = 1'b0;
      if (exe_aluc == ALUC_ADD)
         ovf = (a_op[WIDTH-1] == b_op[WIDTH-1]) && (sum[WIDTH-1] != a_op[WIDTH-1]);
      else if (exe_aluc == ALUC_SUB)
         ovf = (a_op[WIDTH-1] != b_op[WIDTH-1]) && (diff[WIDTH-1] != a_op[WIDTH-1]);
   end
`endif

   exe_iter_shifter #(.WIDTH(WIDTH), .SA_W(SA_W)) u_shifter (
      .clk       (clk),
      .clrn      (clrn),
      .start     (start_shift),
      .dir_right (exe_aluc[1]),
      .arith     (exe_aluc == ALUC_SRA),
      .sa        (sa),
      .b         (b_op),
      .busy      (sh_busy),
      .done      (sh_done),
      .result    (sh_result)
   );

   // Gated by clrn so the upstream sees no stall while reset is held.
   assign stall = clrn && (sh_busy ? !sh_done : start_shift);

   // Bubbles clear only the control bits; data fields keep their last value.
   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         ctrl_q  <= '0;
         mem_rn  <= '0;
         mem_alu <= '0;
         mem_rb  <= '0;
`ifdef EXE_OVF_TRAP_EN
         mem_ovf <= 1'b0;
`endif
      end else begin
         ctrl_q <= '0;
`ifdef EXE_OVF_TRAP_EN
         mem_ovf <= 1'b0;
`endif
         if (sh_busy) begin
            if (sh_done) begin
               ctrl_q  <= exe_ctrl;
               mem_rn  <= exe_rn;
               mem_alu <= sh_result;
               mem_rb  <= exe_rb;
            end
         end else if (exe_valid && !start_shift) begin
            ctrl_q  <= exe_ctrl;
            mem_rn  <= exe_rn;
            mem_alu <= alu_res;
            mem_rb  <= exe_rb;
`ifdef EXE_OVF_TRAP_EN
            if (ovf) begin
               ctrl_q.wreg <= 1'b0;
               mem_ovf     <= 1'b1;
            end
`endif
         end
      end
   end

   assign mem_valid = ctrl_q.valid;
   assign mem_m2reg = ctrl_q.m2reg;
   assign mem_wmem  = ctrl_q.wmem;
   assign mem_wreg  = ctrl_q.wreg;
endmodule

// File: tb/tb_exe_stage.sv
// tb_exe_stage: directed bench for exe_stage. Inputs change on the falling
// edge, outputs are checked on the falling edge (mid-cycle).
module tb_exe_stage;
   logic        clk, clrn;
   logic        exe_valid, exe_m2reg, exe_wmem, exe_aluimm, exe_shift, exe_wreg;
   logic [2:0]  exe_aluc;
   logic [4:0]  exe_rn;
   logic [31:0] exe_ra, exe_rb, exe_imm;
   logic        stall, mem_valid, mem_m2reg, mem_wmem, mem_wreg;
   logic [4:0]  mem_rn;
   logic [31:0] mem_alu, mem_rb;
`ifdef EXE_OVF_TRAP_EN
   logic        mem_ovf;
`endif
   int checks = 0;
   int errors = 0;

   exe_stage dut (
      .clk(clk), .clrn(clrn),
      .exe_valid(exe_valid), .exe_m2reg(exe_m2reg), .exe_wmem(exe_wmem),
      .exe_aluimm(exe_aluimm), .exe_shift(exe_shift), .exe_wreg(exe_wreg),
      .exe_aluc(exe_aluc), .exe_rn(exe_rn), .exe_ra(exe_ra), .exe_rb(exe_rb),
      .exe_imm(exe_imm), .stall(stall), .mem_valid(mem_valid),
      .mem_m2reg(mem_m2reg), .mem_wmem(mem_wmem), .mem_wreg(mem_wreg),
      .mem_rn(mem_rn), .mem_alu(mem_alu),
`ifdef EXE_OVF_TRAP_EN
      .mem_ovf(mem_ovf),
`endif
      .mem_rb(mem_rb)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic v, input logic m2r, input logic wm, input logic ai,
                        input logic sh, input logic wr, input logic [2:0] aluc,
                        input logic [4:0] rn, input logic [31:0] ra,
                        input logic [31:0] rb, input logic [31:0] imm);
      exe_valid = v; exe_m2reg = m2r; exe_wmem = wm; exe_aluimm = ai;
      exe_shift = sh; exe_wreg = wr; exe_aluc = aluc; exe_rn = rn;
      exe_ra = ra; exe_rb = rb; exe_imm = imm;
   endtask

   task automatic bubble();
      drive(0, 0, 0, 0, 0, 0, 3'b000, 5'd0, 32'h0, 32'h0, 32'h0);
   endtask

   initial begin
      clrn = 1'b0;
      bubble();
      repeat (2) @(negedge clk);
      chk("rst_valid", {31'b0, mem_valid}, 32'd0);
      chk("rst_wreg",  {31'b0, mem_wreg},  32'd0);
      chk("rst_alu",   mem_alu, 32'h0);
      chk("rst_stall", {31'b0, stall}, 32'd0);
      clrn = 1'b1;

      // ADD 5+7
      @(negedge clk);
      drive(1, 0, 0, 0, 0, 1, 3'b000, 5'd3, 32'd5, 32'd7, 32'h0);
      #1 chk("add_stall", {31'b0, stall}, 32'd0);
      @(negedge clk);
      chk("add_alu",   mem_alu, 32'd12);
      chk("add_wreg",  {31'b0, mem_wreg}, 32'd1);
      chk("add_rn",    {27'b0, mem_rn}, 32'd3);
      chk("add_valid", {31'b0, mem_valid}, 32'd1);
      bubble();
      @(negedge clk);
      chk("bub_valid", {31'b0, mem_valid}, 32'd0);
      chk("bub_hold",  mem_alu, 32'd12);

      // SRA 0x8000_0000 by 4
      drive(1, 0, 0, 0, 1, 1, 3'b111, 5'd5, 32'h0, 32'h8000_0000, 32'd4 << 6);
      for (int i = 0; i < 4; i++) begin
         #1 chk($sformatf("sra_stall%0d", i), {31'b0, stall}, 32'd1);
         @(negedge clk);
         chk($sformatf("sra_bub%0d", i), {31'b0, mem_valid}, 32'd0);
      end
      chk("sra_stall_end", {31'b0, stall}, 32'd0);
      @(negedge clk);
      chk("sra_alu",   mem_alu, 32'hF800_0000);
      chk("sra_valid", {31'b0, mem_valid}, 32'd1);
      chk("sra_rn",    {27'b0, mem_rn}, 32'd5);

      // SLL by 0
      drive(1, 0, 0, 0, 1, 1, 3'b100, 5'd6, 32'h0, 32'h1234, 32'h0);
      #1 chk("sll0_stall", {31'b0, stall}, 32'd0);
      @(negedge clk);
      chk("sll0_alu",   mem_alu, 32'h1234);
      chk("sll0_valid", {31'b0, mem_valid}, 32'd1);

      // store: address 0x100+8, data 0xDEAD
      drive(1, 0, 1, 1, 0, 0, 3'b000, 5'd0, 32'h100, 32'hDEAD, 32'd8);
      @(negedge clk);
      chk("st_alu",  mem_alu, 32'h108);
      chk("st_rb",   mem_rb, 32'hDEAD);
      chk("st_wmem", {31'b0, mem_wmem}, 32'd1);
      chk("st_wreg", {31'b0, mem_wreg}, 32'd0);

      // remaining single-cycle ops
      drive(1, 0, 0, 0, 0, 1, 3'b001, 5'd1, 32'd10, 32'd3, 32'h0);
      @(negedge clk);
      chk("sub_alu", mem_alu, 32'd7);
      drive(1, 0, 0, 0, 0, 1, 3'b010, 5'd1, 32'hF0F0, 32'hFF00, 32'h0);
      @(negedge clk);
      chk("and_alu", mem_alu, 32'hF000);
      drive(1, 0, 0, 0, 0, 1, 3'b011, 5'd1, 32'hF0F0, 32'hFF00, 32'h0);
      @(negedge clk);
      chk("or_alu", mem_alu, 32'hFFF0);
      drive(1, 0, 0, 0, 0, 1, 3'b100, 5'd1, 32'hF0F0, 32'hFF00, 32'h0);
      @(negedge clk);
      chk("xor_alu", mem_alu, 32'h0FF0);
      drive(1, 0, 0, 1, 0, 1, 3'b101, 5'd1, 32'h0, 32'h0, 32'h1234);
      @(negedge clk);
      chk("lui_alu", mem_alu, 32'h1234_0000);

      // invalid shift in IDLE: bubble, no stall
      drive(0, 0, 0, 0, 1, 1, 3'b110, 5'd2, 32'h0, 32'h55, 32'd3 << 6);
      #1 chk("inv_stall", {31'b0, stall}, 32'd0);
      @(negedge clk);
      chk("inv_valid", {31'b0, mem_valid}, 32'd0);

      // SRL by 31, reset in shift cycle 10
      drive(1, 0, 0, 0, 1, 1, 3'b110, 5'd9, 32'h0, 32'hFFFF_FFFF, 32'd31 << 6);
      repeat (10) @(negedge clk);
      chk("srl_stall_mid", {31'b0, stall}, 32'd1);
      chk("srl_bub_mid",   {31'b0, mem_valid}, 32'd0);
      clrn = 1'b0;
      drive(1, 0, 0, 0, 0, 1, 3'b000, 5'd4, 32'd1, 32'd2, 32'h0);
      #1;
      chk("rstm_stall", {31'b0, stall}, 32'd0);
      chk("rstm_alu",   mem_alu, 32'h0);
      chk("rstm_rb",    mem_rb, 32'h0);
      chk("rstm_rn",    {27'b0, mem_rn}, 32'd0);
      #1 clrn = 1'b1;
      #1 chk("post_stall", {31'b0, stall}, 32'd0);
      @(negedge clk);
      chk("post_alu",   mem_alu, 32'd3);
      chk("post_valid", {31'b0, mem_valid}, 32'd1);
      chk("post_rn",    {27'b0, mem_rn}, 32'd4);

      // signed overflow on ADD
      drive(1, 0, 0, 0, 0, 1, 3'b000, 5'd7, 32'h7FFF_FFFF, 32'd1, 32'h0);
      @(negedge clk);
      chk("ovf_alu",   mem_alu, 32'h8000_0000);
      chk("ovf_valid", {31'b0, mem_valid}, 32'd1);
`ifdef EXE_OVF_TRAP_EN
      chk("ovf_flag", {31'b0, mem_ovf}, 32'd1);
      chk("ovf_wreg", {31'b0, mem_wreg}, 32'd0);
`else
      chk("ovf_wreg", {31'b0, mem_wreg}, 32'd1);
`endif
      drive(1, 0, 0, 0, 0, 1, 3'b001, 5'd7, 32'd1, 32'd2, 32'h0);
      @(negedge clk);
      chk("sub_neg_alu", mem_alu, 32'hFFFF_FFFF);
      chk("sub_neg_wreg", {31'b0, mem_wreg}, 32'd1);
`ifdef EXE_OVF_TRAP_EN
      chk("ovf_clear", {31'b0, mem_ovf}, 32'd0);
`endif
      bubble();
      @(negedge clk);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
